// File: rtl/imem_loader_pkg.sv
// Shared CPU definitions for the instruction memory and its program loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 12;
  localparam int unsigned IMEM_DATA_W = 16;
  localparam int unsigned IMEM_DEPTH  = 4096;

  // Loader state encoding, shared with anything that observes the loader.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DAT_HI = 3'd3,
    DAT_LO = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } ld_state_e;

  // A load is active (bytes accepted, CPU stalled) in every state from
  // CNT_HI through CHK.
  function automatic logic loader_busy(input logic [2:0] s);
    return (s == CNT_HI) || (s == CNT_LO) || (s == DAT_HI) ||
           (s == DAT_LO) || (s == CHK);
  endfunction

  // Word counts larger than the memory cannot be loaded.
  function automatic logic count_oversize(input logic [15:0] n);
    return n > 16'(IMEM_DEPTH);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  // Loader side: consumes the stream, drives the memory write port.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  // Environment side: byte source plus the instruction memory.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles big-endian words from a framed byte stream,
// writes them from address 0 upward and verifies an XOR checksum while
// holding the CPU fetch stage in stall.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err
);

  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_CNT_HI = CNT_HI;
  localparam logic [2:0] S_CNT_LO = CNT_LO;
  localparam logic [2:0] S_DAT_HI = DAT_HI;
  localparam logic [2:0] S_DAT_LO = DAT_LO;
  localparam logic [2:0] S_CHK    = CHK;
  localparam logic [2:0] S_DONE   = DONE;
  localparam logic [2:0] S_ERR    = ERR;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        cnt_hi_q;
  logic [7:0]        hi_q;
  logic [7:0]        csum_q;
  logic [12:0]       rem_q;

  logic              accept;
  logic              start_acc;
  logic [15:0]       count_n;

  assign accept    = bus.in_valid && ready_q;
  assign count_n   = {cnt_hi_q, bus.in_data};
  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                               (state_q == S_ERR));

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  // Next-state: every advance is gated by a byte handshake, except leaving
  // the idle/terminal states, which only needs start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (accept) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (accept) begin
          if (count_n == 16'd0)             state_d = S_CHK;
          else if (count_oversize(count_n)) state_d = S_ERR;
          else                              state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (accept) state_d = S_DAT_LO;
      end
      S_DAT_LO: begin
        if (accept) state_d = (rem_q == 13'd1) ? S_CHK : S_DAT_HI;
      end
      S_CHK: begin
        if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State plus the outputs that are pure registered functions of it; built
  // from state_d so hold and done/err change on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= loader_busy(state_d);
      cpu_hold  <= loader_busy(state_d);
      load_done <= (state_d == S_DONE);
      load_err  <= (state_d == S_ERR);
    end
  end

  // Frame bookkeeping: count high byte, word high byte, words left, checksum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_hi_q <= '0;
      hi_q     <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
    end else begin
      if (start_acc) begin
        csum_q <= '0;
      end else if (accept) begin
        csum_q <= csum_q ^ bus.in_data;
      end
      if (accept && (state_q == S_CNT_HI)) cnt_hi_q <= bus.in_data;
      if (accept && (state_q == S_DAT_HI)) hi_q     <= bus.in_data;
      if (accept && (state_q == S_CNT_LO)) begin
        rem_q <= count_n[12:0];
      end else if (accept && (state_q == S_DAT_LO)) begin
        rem_q <= rem_q - 13'd1;
      end
    end
  end

  // Memory write port: one-cycle strobe after each low byte; the address
  // steps after the strobe so it is stable while the write happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      we_q <= accept && (state_q == S_DAT_LO);
      if (accept && (state_q == S_DAT_LO)) begin
        wdata_q <= DATA_W'({hi_q, bus.in_data});
      end
      if (start_acc) begin
        addr_q <= '0;
      end else if (we_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level reference model fills
// scoreboard queues; independent monitors check memory writes and status.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic cpu_hold;
  logic load_done;
  logic load_err;

  imem_loader_if #(.ADDR_W(IMEM_ADDR_W), .DATA_W(IMEM_DATA_W)) bus ();

  imem_loader #(.ADDR_W(IMEM_ADDR_W), .DATA_W(IMEM_DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [27:0] exp_wq[$];   // {addr, data} of every write the model predicts
  logic [1:0]  exp_sq[$];   // {done, err} at the end of each completed frame
  logic [15:0] dut_mem[IMEM_DEPTH];
  logic [15:0] exp_mem[IMEM_DEPTH];

  logic prev_we  = 1'b0;
  logic prev_fin = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name, input string detail);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] f[$]);
    logic [7:0] x = 8'h00;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  // Reference model: decides from the delivered bytes alone which words land
  // where and how the frame ends (if it ends).
  task automatic model_frame(input logic [7:0] b[$]);
    int unsigned n;
    logic [7:0]  body[$];
    logic [15:0] w;
    n = {b[0], b[1]};
    if (n > IMEM_DEPTH) begin
      exp_sq.push_back(2'b01);
      return;
    end
    for (int unsigned i = 0; i < n; i++) begin
      if (3 + 2 * i < b.size()) begin
        w = {b[2 + 2 * i], b[3 + 2 * i]};
        exp_wq.push_back({12'(i), w});
        exp_mem[i] = w;
      end
    end
    if (b.size() == 2 * n + 3) begin
      body = b[0:2 * n + 1];
      exp_sq.push_back((xor_all(body) == b[2 * n + 2]) ? 2'b10 : 2'b01);
    end
  endtask

  task automatic build_frame(input int unsigned n, input bit good, output logic [7:0] f[$]);
    logic [7:0]  x;
    logic [15:0] n16;
    n16 = 16'(n);
    f = {};
    f.push_back(n16[15:8]);
    f.push_back(n16[7:0]);
    for (int unsigned i = 0; i < 2 * n; i++) f.push_back(8'($urandom));
    x = xor_all(f);
    f.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
  endtask

  task automatic start_load();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("ready_after_start", 32'(bus.in_ready), 1);
    check("hold_after_start", 32'(cpu_hold), 1);
  endtask

  // Offers bytes, optionally with idle gaps and stray start pulses; a byte is
  // consumed when valid and ready are both high across a rising edge.
  task automatic send(input logic [7:0] f[$], input bit gaps, input bit pokes,
                      output int unsigned cycles);
    int unsigned idx  = 0;
    int unsigned idle = 0;
    bit hs;
    cycles = 0;
    while (idx < f.size()) begin
      @(negedge clk);
      if (gaps && ($urandom_range(2) == 0)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = f[idx];
      end
      start = pokes && ($urandom_range(5) == 0);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      cycles++;
      if (hs) begin
        idx++;
        idle = 0;
      end else begin
        idle++;
        if (idle > 100) begin
          report_fail("send_stall", $sformatf("byte %0d of %0d never accepted", idx, f.size()));
          break;
        end
      end
    end
    #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (exp_wq.size() == 0 && exp_sq.size() == 0) return;
      @(negedge clk);
    end
    report_fail(name, $sformatf("%0d writes and %0d status results still pending",
                                exp_wq.size(), exp_sq.size()));
    exp_wq.delete();
    exp_sq.delete();
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit gaps, input bit pokes, input string name);
    int unsigned cyc;
    model_frame(f);
    start_load();
    send(f, gaps, pokes, cyc);
    wait_drain(name);
  endtask

  // Write monitor: every strobe must match the next predicted write.
  initial begin : write_monitor
    logic [27:0] e;
    forever begin
      @(negedge clk);
      if (bus.imem_we) begin
        check("we_single_cycle", 32'(prev_we), 0);
        if (exp_wq.size() == 0) begin
          report_fail("unexpected_write", $sformatf("addr %0h data %0h", bus.imem_addr, bus.imem_wdata));
        end else begin
          e = exp_wq.pop_front();
          check("write_addr", 32'(bus.imem_addr), 32'(e[27:16]));
          check("write_data", 32'(bus.imem_wdata), 32'(e[15:0]));
        end
        dut_mem[bus.imem_addr] = bus.imem_wdata;
      end
      prev_we = bus.imem_we;
    end
  end

  // Status monitor: end-of-load flags, stall release, hold during load.
  initial begin : status_monitor
    logic [1:0] s;
    logic       fin;
    forever begin
      @(negedge clk);
      if (bus.in_ready) check("hold_during_load", 32'(cpu_hold), 1);
      fin = load_done | load_err;
      if (fin && !prev_fin) begin
        if (exp_sq.size() == 0) begin
          report_fail("unexpected_status", $sformatf("done %0b err %0b", load_done, load_err));
        end else begin
          s = exp_sq.pop_front();
          check("status_done", 32'(load_done), 32'(s[1]));
          check("status_err", 32'(load_err), 32'(s[0]));
          check("hold_released", 32'(cpu_hold), 0);
          check("ready_low_at_end", 32'(bus.in_ready), 0);
        end
      end
      prev_fin = fin;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  f[$];
    logic [7:0]  g[$];
    int unsigned cyc;
    int unsigned mism;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      dut_mem[i] = 16'hDEAD;
      exp_mem[i] = 16'hDEAD;
    end

    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_imem_we", 32'(bus.imem_we), 0);
    check("rst_imem_addr", 32'(bus.imem_addr), 0);
    check("rst_imem_wdata", 32'(bus.imem_wdata), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_err", 32'(load_err), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three fixed words with the correct checksum.
    f = {8'h00, 8'h03, 8'h61, 8'h41, 8'h62, 8'h42, 8'h91, 8'h14};
    f.push_back(xor_all(f));
    run_frame(f, 1'b0, 1'b0, "n3_good");
    check("n3_good_done", 32'(load_done), 1);
    check("n3_good_hold", 32'(cpu_hold), 0);

    // Same words, checksum forced to 0x00 (the true XOR is nonzero).
    f[8] = 8'h00;
    run_frame(f, 1'b0, 1'b0, "n3_bad");
    check("n3_bad_err", 32'(load_err), 1);
    check("n3_bad_done", 32'(load_done), 0);

    // Oversize count: error one cycle after count_lo, no writes.
    f = {8'h10, 8'h01};
    model_frame(f);
    start_load();
    send(f, 1'b0, 1'b0, cyc);
    @(negedge clk);
    check("oversize_err_next_cycle", 32'(load_err), 1);
    check("oversize_ready", 32'(bus.in_ready), 0);
    check("oversize_hold", 32'(cpu_hold), 0);
    wait_drain("oversize");

    // Empty program.
    f = {8'h00, 8'h00, 8'h00};
    run_frame(f, 1'b0, 1'b0, "n0");
    check("n0_done", 32'(load_done), 1);

    // Random short frames with stream gaps, good and bad checksums.
    for (int k = 0; k < 4; k++) begin
      build_frame($urandom_range(12, 1), bit'($urandom_range(1)), f);
      run_frame(f, 1'b1, 1'b0, "random_frame");
    end

    // Nine words with gaps and ignored start pulses mid-load.
    build_frame(9, 1'b1, f);
    run_frame(f, 1'b1, 1'b1, "n9_pokes");
    check("n9_done", 32'(load_done), 1);

    // Full memory load at one byte per cycle; address wraps after the last word.
    build_frame(IMEM_DEPTH, 1'b1, f);
    model_frame(f);
    start_load();
    send(f, 1'b0, 1'b0, cyc);
    check("full_load_cycles", cyc, 8195);
    wait_drain("full_load");
    check("full_load_done", 32'(load_done), 1);
    check("full_load_addr_wrap", 32'(bus.imem_addr), 0);

    // Reset after two of five words.
    build_frame(5, 1'b1, f);
    g = f[0:5];
    model_frame(g);
    start_load();
    send(g, 1'b0, 1'b0, cyc);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 0);
    check("mid_rst_imem_we", 32'(bus.imem_we), 0);
    check("mid_rst_imem_addr", 32'(bus.imem_addr), 0);
    check("mid_rst_imem_wdata", 32'(bus.imem_wdata), 0);
    check("mid_rst_cpu_hold", 32'(cpu_hold), 0);
    check("mid_rst_load_done", 32'(load_done), 0);
    check("mid_rst_load_err", 32'(load_err), 0);
    bus.in_valid = 1'b1;
    bus.in_data  = f[6];
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_drain("mid_reset");
    check("mid_rst_addr2_kept", 32'(dut_mem[2]), 32'(exp_mem[2]));

    mism = 0;
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      if (dut_mem[i] !== exp_mem[i]) mism++;
    end
    check("memory_image_mismatches", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
